// File: rtl/param_shift_register.sv
// WIDTH-bit D-flip-flop register bank: load/hold/clear, shift/rotate both ways, and a bulk
// engine that runs amt shift/rotate steps with a busy/done handshake. Optional PSR_PARITY_EN.
module param_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
`ifdef PSR_PARITY_EN
  output logic             done,
  output logic             parity
`else
  output logic             done
`endif
);

  typedef enum logic [2:0] {
    OpHold = 3'd0,
    OpLoad = 3'd1,
    OpShl  = 3'd2,
    OpShr  = 3'd3,
    OpRotl = 3'd4,
    OpRotr = 3'd5,
    OpClr  = 3'd6,
    OpRsvd = 3'd7
  } op_e;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;

  op_e  mode_op;
  logic bulk_ok;
  logic do_step;
  op_e  step_op;

  assign mode_op = op_e'(mode);
  // Only shifts/rotates with a non-zero count actually enter RUN.
  assign bulk_ok = (mode_op inside {OpShl, OpShr, OpRotl, OpRotr}) && (amt != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OpHold;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && bulk_ok) state_d = StRun;
      StRun:  if (cnt_q == AMT_W'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    do_step = 1'b0;
    step_op = OpHold;
    if (state_q == StRun) begin
      do_step = 1'b1;
      step_op = op_q;
      cnt_d   = cnt_q - AMT_W'(1);
      if (cnt_q == AMT_W'(1)) done_d = 1'b1;
    end else if (start) begin
      op_d = mode_op;
      if (bulk_ok) cnt_d = amt;
      else         done_d = 1'b1;
    end else if (en) begin
      do_step = 1'b1;
      step_op = mode_op;
    end

    q_d    = q_q;
    sout_d = sout_q;
    if (do_step) begin
      unique case (step_op)
        OpLoad: q_d = d;
        OpShl: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
        end
        OpShr: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        OpRotl: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        OpRotr: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        OpClr: begin
          q_d    = '0;
          sout_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    q    = q_q;
    sout = sout_q;
    busy = (state_q == StRun);
    done = done_q;
  end

`ifdef PSR_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^q_d;
  end

  assign parity = parity_q;
`endif

endmodule
